// File: rtl/shifter_pipe_pkg.sv
// Shared types and configuration helpers for the pipelined ARM operand-2 shifter.
package shifter_pkg;

    localparam int unsigned BRANCH_OFFSET_W = 24;

    typedef enum logic [1:0] {
        MODE_IMM     = 2'd0,
        MODE_REG     = 2'd1,
        MODE_ROT_IMM = 2'd2,
        MODE_BRANCH  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_type_t;

    function automatic bit width_is_legal(input int unsigned w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// Operand/result handshake bundle between register read, the shifter and the ALU.
interface shifter_pipe_if
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned AW = $clog2(WIDTH);

    logic                       in_valid;
    logic                       in_ready;
    mode_t                      mode;
    shift_type_t                shift_type;
    logic [AW-1:0]              shift_imm;
    logic [7:0]                 shift_reg;
    logic [11:0]                imm12;
    logic [BRANCH_OFFSET_W-1:0] branch_offset;
    logic [WIDTH-1:0]           rm_data;
    logic                       carry_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic                       out_carry;

    modport master (
        output in_valid, mode, shift_type, shift_imm, shift_reg, imm12,
               branch_offset, rm_data, carry_in, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );

    modport slave (
        input  in_valid, mode, shift_type, shift_imm, shift_reg, imm12,
               branch_offset, rm_data, carry_in, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );

endinterface

// File: rtl/shifter_pipe_barrel_core.sv
// Amount decode (ARM special cases folded into operand/amount/carry) and a log-stage barrel shifter.
module barrel_core
    import shifter_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned AW    = $clog2(WIDTH)
) (
    input  mode_t                      i_mode,
    input  shift_type_t                i_shift_type,
    input  logic [AW-1:0]              i_shift_imm,
    input  logic [7:0]                 i_shift_reg,
    input  logic [11:0]                i_imm12,
    input  logic [BRANCH_OFFSET_W-1:0] i_branch_offset,
    input  logic [WIDTH-1:0]           i_rm,
    input  logic                       i_carry_in,
    output logic [WIDTH-1:0]           o_dec_operand,
    output logic [AW-1:0]              o_dec_amt,
    output shift_type_t                o_dec_op,
    output logic                       o_dec_carry,
    input  logic [WIDTH-1:0]           i_sh_operand,
    input  logic [AW-1:0]              i_sh_amt,
    input  shift_type_t                i_sh_op,
    input  logic                       i_sh_carry,
    output logic [WIDTH-1:0]           o_result,
    output logic                       o_carry
);
    localparam logic [8:0] W9 = 9'(WIDTH);

    logic             w_msb;
    logic [AW-1:0]    w_imm_neg, w_imm_m1;
    logic [AW-1:0]    w_reg_lo, w_reg_neg, w_reg_m1;
    logic             w_reg_lt, w_reg_eq;
    logic [AW-1:0]    w_rot_amt, w_rot_m1;
    logic [WIDTH-1:0] w_imm8_z, w_branch_sx;

    assign w_msb       = i_rm[WIDTH-1];
    assign w_imm_neg   = '0 - i_shift_imm;
    assign w_imm_m1    = i_shift_imm - AW'(1);
    assign w_reg_lo    = i_shift_reg[AW-1:0];
    assign w_reg_neg   = '0 - w_reg_lo;
    assign w_reg_m1    = w_reg_lo - AW'(1);
    assign w_reg_lt    = {1'b0, i_shift_reg} < W9;
    assign w_reg_eq    = {1'b0, i_shift_reg} == W9;
    assign w_rot_amt   = AW'({i_imm12[11:8], 1'b0});
    assign w_rot_m1    = w_rot_amt - AW'(1);
    assign w_imm8_z    = {{(WIDTH-8){1'b0}}, i_imm12[7:0]};
    assign w_branch_sx = {{(WIDTH-BRANCH_OFFSET_W-2){i_branch_offset[BRANCH_OFFSET_W-1]}},
                          i_branch_offset, 2'b00};

    // Every case reduces to operand + in-range amount + precomputed carry:
    // out-of-range results become a zero operand, ASR saturation becomes ASR by W-1.
    always_comb begin
        o_dec_operand = i_rm;
        o_dec_amt     = '0;
        o_dec_op      = SH_LSL;
        o_dec_carry   = i_carry_in;
        unique case (i_mode)
            MODE_IMM: begin
                if (i_shift_imm == '0) begin
                    unique case (i_shift_type)
                        SH_LSL: ;
                        SH_LSR: begin
                            o_dec_operand = '0;
                            o_dec_carry   = w_msb;
                        end
                        SH_ASR: begin
                            o_dec_op    = SH_ASR;
                            o_dec_amt   = '1;
                            o_dec_carry = w_msb;
                        end
                        SH_ROR: begin
                            o_dec_operand = {i_carry_in, i_rm[WIDTH-1:1]};
                            o_dec_carry   = i_rm[0];
                        end
                    endcase
                end else begin
                    o_dec_op    = i_shift_type;
                    o_dec_amt   = i_shift_imm;
                    o_dec_carry = (i_shift_type == SH_LSL) ? i_rm[w_imm_neg] : i_rm[w_imm_m1];
                end
            end
            MODE_REG: begin
                if (i_shift_reg != '0) begin
                    unique case (i_shift_type)
                        SH_LSL, SH_LSR: begin
                            if (w_reg_lt) begin
                                o_dec_op    = i_shift_type;
                                o_dec_amt   = w_reg_lo;
                                o_dec_carry = (i_shift_type == SH_LSL) ? i_rm[w_reg_neg]
                                                                       : i_rm[w_reg_m1];
                            end else begin
                                o_dec_operand = '0;
                                o_dec_carry   = w_reg_eq &&
                                                ((i_shift_type == SH_LSL) ? i_rm[0] : w_msb);
                            end
                        end
                        SH_ASR: begin
                            o_dec_op = SH_ASR;
                            if (w_reg_lt) begin
                                o_dec_amt   = w_reg_lo;
                                o_dec_carry = i_rm[w_reg_m1];
                            end else begin
                                o_dec_amt   = '1;
                                o_dec_carry = w_msb;
                            end
                        end
                        SH_ROR: begin
                            // A multiple of W wraps w_reg_m1 to W-1, which is the required MSB carry.
                            o_dec_op    = SH_ROR;
                            o_dec_amt   = w_reg_lo;
                            o_dec_carry = i_rm[w_reg_m1];
                        end
                    endcase
                end
            end
            MODE_ROT_IMM: begin
                o_dec_operand = w_imm8_z;
                o_dec_op      = SH_ROR;
                o_dec_amt     = w_rot_amt;
                o_dec_carry   = (i_imm12[11:8] == 4'd0) ? i_carry_in : w_imm8_z[w_rot_m1];
            end
            MODE_BRANCH: begin
                o_dec_operand = w_branch_sx;
            end
        endcase
    end

    logic [WIDTH-1:0] w_rev_in, w_rev_out, w_pre;
    logic [WIDTH-1:0] w_stage [AW+1];
    logic             w_fill;

    // Left shifts run through the right-shifting network on a bit-reversed operand.
    assign w_rev_in   = {<<{i_sh_operand}};
    assign w_pre      = (i_sh_op == SH_LSL) ? w_rev_in : i_sh_operand;
    assign w_fill     = (i_sh_op == SH_ASR) && i_sh_operand[WIDTH-1];
    assign w_stage[0] = w_pre;

    for (genvar s = 0; s < AW; s++) begin : g_stage
        localparam int unsigned SH = 1 << s;
        assign w_stage[s+1] = !i_sh_amt[s]       ? w_stage[s] :
                              (i_sh_op == SH_ROR) ? {w_stage[s][SH-1:0], w_stage[s][WIDTH-1:SH]}
                                                  : {{SH{w_fill}}, w_stage[s][WIDTH-1:SH]};
    end

    assign w_rev_out = {<<{w_stage[AW]}};
    assign o_result  = (i_sh_op == SH_LSL) ? w_rev_out : w_stage[AW];
    assign o_carry   = i_sh_carry;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined operand-2 shifter: valid pipeline and global-advance stall around barrel_core.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic          clk,
    input  logic          reset,
    shifter_pipe_if.slave bus
);
    localparam int unsigned AW = $clog2(WIDTH);

    if (!width_is_legal(WIDTH) || !(PIPE_STAGES inside {1, 2})) begin : g_bad_cfg
        $error("shifter_pipe: unsupported WIDTH or PIPE_STAGES");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_dec_operand, w_sh_operand, w_result;
    logic [AW-1:0]    w_dec_amt, w_sh_amt;
    shift_type_t      w_dec_op, w_sh_op;
    logic             w_dec_carry, w_sh_carry, w_result_carry;
    logic             w_sh_valid;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_carry;

    assign w_adv         = bus.out_ready || !r_out_valid;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_carry = r_out_carry;

    barrel_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_mode          (bus.mode),
        .i_shift_type    (bus.shift_type),
        .i_shift_imm     (bus.shift_imm),
        .i_shift_reg     (bus.shift_reg),
        .i_imm12         (bus.imm12),
        .i_branch_offset (bus.branch_offset),
        .i_rm            (bus.rm_data),
        .i_carry_in      (bus.carry_in),
        .o_dec_operand   (w_dec_operand),
        .o_dec_amt       (w_dec_amt),
        .o_dec_op        (w_dec_op),
        .o_dec_carry     (w_dec_carry),
        .i_sh_operand    (w_sh_operand),
        .i_sh_amt        (w_sh_amt),
        .i_sh_op         (w_sh_op),
        .i_sh_carry      (w_sh_carry),
        .o_result        (w_result),
        .o_carry         (w_result_carry)
    );

    if (PIPE_STAGES == 2) begin : g_two_stage
        logic             r_s1_valid;
        logic [WIDTH-1:0] r_s1_operand;
        logic [AW-1:0]    r_s1_amt;
        shift_type_t      r_s1_op;
        logic             r_s1_carry;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_s1_valid   <= 1'b0;
                r_s1_operand <= '0;
                r_s1_amt     <= '0;
                r_s1_op      <= SH_LSL;
                r_s1_carry   <= 1'b0;
            end else if (w_adv) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_operand <= w_dec_operand;
                    r_s1_amt     <= w_dec_amt;
                    r_s1_op      <= w_dec_op;
                    r_s1_carry   <= w_dec_carry;
                end
            end
        end

        assign w_sh_valid   = r_s1_valid;
        assign w_sh_operand = r_s1_operand;
        assign w_sh_amt     = r_s1_amt;
        assign w_sh_op      = r_s1_op;
        assign w_sh_carry   = r_s1_carry;
    end else begin : g_one_stage
        assign w_sh_valid   = bus.in_valid;
        assign w_sh_operand = w_dec_operand;
        assign w_sh_amt     = w_dec_amt;
        assign w_sh_op      = w_dec_op;
        assign w_sh_carry   = w_dec_carry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_carry <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_sh_valid;
            if (w_sh_valid) begin
                r_out_data  <= w_result;
                r_out_carry <= w_result_carry;
            end
        end
    end

endmodule
